// File: rtl/osc_freq_meter_pkg.sv
// ============================================================================
// Module   : osc_meas_pkg
// Brief    : Shared state encoding and sizing helper for the oscillator meter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package osc_meas_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    GATE   = 2'd2,
    HOLD   = 2'd3
  } osc_meas_state_t;

  function automatic int gate_cnt_w(input int gate_cycles);
    return $clog2(gate_cycles + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/osc_freq_meter_if.sv
// ============================================================================
// Module   : osc_freq_meter_if
// Brief    : Control and result handshake bundle between controller and meter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface osc_freq_meter_if #(
  parameter int CNT_W = 16
);

  logic             start;
  logic             continuous;
  logic             busy;
  logic             meas_valid;
  logic             meas_ready;
  logic [CNT_W-1:0] meas_count;
  logic             meas_overflow;

  modport master (
    output start, continuous, meas_ready,
    input  busy, meas_valid, meas_count, meas_overflow
  );

  modport slave (
    input  start, continuous, meas_ready,
    output busy, meas_valid, meas_count, meas_overflow
  );

endinterface

`default_nettype wire

// File: rtl/osc_edge_sync.sv
// ============================================================================
// Module   : osc_edge_sync
// Brief    : Synchronises an asynchronous oscillator input and flags rising edges.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module osc_edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic osc_i,
  output logic rise_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], osc_i};
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise_o = sync_q[SYNC_STAGES-1] & ~hist_q;

endmodule

`default_nettype wire

// File: rtl/osc_freq_meter.sv
// ============================================================================
// Module   : osc_freq_meter
// Brief    : Counts oscillator rising edges over a fixed reference-clock gate.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module osc_freq_meter
  import osc_meas_pkg::*;
#(
  parameter int GATE_CYCLES = 1000,
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             osc_in_i,
  osc_freq_meter_if.slave  meas_if
);

  localparam int               TMR_MAX = (GATE_CYCLES > SYNC_STAGES) ? GATE_CYCLES : SYNC_STAGES;
  localparam int               TMR_W   = gate_cnt_w(TMR_MAX);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  osc_meas_state_t  state_q;
  logic [TMR_W-1:0] tmr_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             busy_q;
  logic             valid_q;
  logic             rise;

  osc_edge_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_edge_sync (
    .clk    (clk),
    .rst    (rst),
    .osc_i  (osc_in_i),
    .rise_o (rise)
  );

  // Saturating increment; a rise seen at full scale only marks overflow.
  always_comb begin
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if (state_q == GATE && rise) begin
      if (cnt_q == CNT_MAX) ovf_d = 1'b1;
      else                  cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      tmr_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      case (state_q)
        IDLE: begin
          if (meas_if.start || meas_if.continuous) begin
            state_q <= SETTLE;
            busy_q  <= 1'b1;
            tmr_q   <= TMR_W'(SYNC_STAGES);
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
          end
        end
        SETTLE: begin
          if (tmr_q == '0) begin
            state_q <= GATE;
            tmr_q   <= TMR_W'(GATE_CYCLES - 1);
          end else begin
            tmr_q <= tmr_q - 1'b1;
          end
        end
        GATE: begin
          if (tmr_q == '0) begin
            state_q <= HOLD;
            valid_q <= 1'b1;
          end else begin
            tmr_q <= tmr_q - 1'b1;
          end
        end
        HOLD: begin
          if (meas_if.meas_ready) begin
            valid_q <= 1'b0;
            if (meas_if.continuous) begin
              state_q <= SETTLE;
              tmr_q   <= TMR_W'(SYNC_STAGES);
              cnt_q   <= '0;
              ovf_q   <= 1'b0;
            end else begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign meas_if.busy          = busy_q;
  assign meas_if.meas_valid    = valid_q;
  assign meas_if.meas_count    = cnt_q;
  assign meas_if.meas_overflow = ovf_q;

endmodule

`default_nettype wire
